// File: rtl/decode_hazard_stage.sv
// decode_hazard_stage: MIPS-style instruction decode with a register file,
// write-back bypass and load-use hazard detection. An ID latch holds the
// fetched instruction, and an output latch presents the decoded operands to
// execute under a valid/ready handshake.
module decode_hazard_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 26,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr_in,
    input  logic [DATA_W-1:0]     pc_seq_in,
    input  logic [CTRL_W-1:0]     ctrl_in,
    input  logic                  flush,
    input  logic                  ex_load_valid,
    input  logic [REG_ADDR_W-1:0] ex_load_dest,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     operand_a_out,
    output logic [DATA_W-1:0]     operand_b_out,
    output logic [DATA_W-1:0]     store_data_out,
    output logic [REG_ADDR_W-1:0] dest_out,
    output logic [CTRL_W-1:0]     ctrl_out,
    output logic [DATA_W-1:0]     pc_seq_out,
    output logic [15:0]           stall_count_out
);

    localparam int NUM_REGS = 1 << REG_ADDR_W;

    logic [DATA_W-1:0]     reg_file [NUM_REGS];

    logic                  id_valid;
    logic [31:0]           id_instr;
    logic [DATA_W-1:0]     id_pc_seq;
    logic [CTRL_W-1:0]     id_ctrl;

    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [REG_ADDR_W-1:0] dest_addr;
    logic                  use_imm;
    logic                  imm_unsigned;
    logic                  uses_rt;
    logic [1:0]            dest_sel;
    logic [DATA_W-1:0]     rs_value;
    logic [DATA_W-1:0]     rt_value;
    logic [DATA_W-1:0]     imm_value;
    logic [DATA_W-1:0]     operand_b;
    logic                  wb_permit;
    logic                  hazard;
    logic                  advance;
    logic                  capture;

    // The opcode field is only carried through; decode is driven by ctrl.
    logic                  unused_opcode;
    assign unused_opcode = ^id_instr[31:26];

    // Field extraction, immediate generation and destination selection.
    always_comb begin
        rs_addr      = REG_ADDR_W'(id_instr[25:21]);
        rt_addr      = REG_ADDR_W'(id_instr[20:16]);
        rd_addr      = REG_ADDR_W'(id_instr[15:11]);
        use_imm      = id_ctrl[0];
        imm_unsigned = id_ctrl[1];
        uses_rt      = id_ctrl[2];
        dest_sel     = id_ctrl[4:3];
        if (imm_unsigned) begin
            imm_value = DATA_W'(id_instr[15:0]);
        end else begin
            imm_value = DATA_W'($signed(id_instr[15:0]));
        end
        case (dest_sel)
            2'b00:   dest_addr = rt_addr;
            2'b01:   dest_addr = rd_addr;
            2'b10:   dest_addr = '1;
            default: dest_addr = '0;
        endcase
    end

    // Register reads with same-cycle write-back bypass; r0 is hardwired when enabled.
    always_comb begin
        wb_permit = wb_en && ((ZERO_REG == 0) || (wb_dest != '0));
        rs_value  = reg_file[rs_addr];
        rt_value  = reg_file[rt_addr];
        if (wb_permit && (wb_dest == rs_addr)) begin
            rs_value = wb_data;
        end
        if (wb_permit && (wb_dest == rt_addr)) begin
            rt_value = wb_data;
        end
        if ((ZERO_REG != 0) && (rs_addr == '0)) begin
            rs_value = '0;
        end
        if ((ZERO_REG != 0) && (rt_addr == '0)) begin
            rt_value = '0;
        end
        operand_b = use_imm ? imm_value : rt_value;
    end

    // Load-use hazard detection and pipeline handshake control.
    always_comb begin
        hazard   = id_valid && ex_load_valid && (ex_load_dest != '0) &&
                   ((ex_load_dest == rs_addr) || (uses_rt && (ex_load_dest == rt_addr)));
        advance  = !out_valid || out_ready;
        in_ready = !flush && (!id_valid || (advance && !hazard));
        capture  = in_valid && in_ready;
    end

    // Register file write port; reset clears every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_file[i] <= '0;
            end
        end else if (wb_permit) begin
            reg_file[wb_dest] <= wb_data;
        end
    end

    // ID latch: capture a new instruction, otherwise empty once it has moved on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid  <= 1'b0;
            id_instr  <= '0;
            id_pc_seq <= '0;
            id_ctrl   <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (capture) begin
            id_valid  <= 1'b1;
            id_instr  <= instr_in;
            id_pc_seq <= pc_seq_in;
            id_ctrl   <= ctrl_in;
        end else if (advance && !hazard) begin
            id_valid <= 1'b0;
        end
    end

    // Output latch: load decoded contents on advance, inserting a bubble on hazard.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid      <= 1'b0;
            operand_a_out  <= '0;
            operand_b_out  <= '0;
            store_data_out <= '0;
            dest_out       <= '0;
            ctrl_out       <= '0;
            pc_seq_out     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            out_valid      <= id_valid && !hazard;
            operand_a_out  <= rs_value;
            operand_b_out  <= operand_b;
            store_data_out <= rt_value;
            dest_out       <= dest_addr;
            ctrl_out       <= id_ctrl;
            pc_seq_out     <= id_pc_seq;
        end
    end

    // Saturating count of cycles spent inserting hazard bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_out <= '0;
        end else if (!flush && hazard && advance && (stall_count_out != 16'hFFFF)) begin
            stall_count_out <= stall_count_out + 16'd1;
        end
    end

endmodule

// File: tb/tb_decode_hazard_stage.sv
// tb_decode_hazard_stage: directed and randomized stimulus against a
// transaction-level reference model; expected outputs are queued at each
// handshake and a separate monitor compares them with what the DUT presents.
module tb_decode_hazard_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 26;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   instr_in = '0;
    logic [DW-1:0] pc_seq_in = '0;
    logic [CW-1:0] ctrl_in = '0;
    logic          flush = 1'b0;
    logic          ex_load_valid = 1'b0;
    logic [AW-1:0] ex_load_dest = '0;
    logic          wb_en = 1'b0;
    logic [AW-1:0] wb_dest = '0;
    logic [DW-1:0] wb_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] operand_a_out;
    logic [DW-1:0] operand_b_out;
    logic [DW-1:0] store_data_out;
    logic [AW-1:0] dest_out;
    logic [CW-1:0] ctrl_out;
    logic [DW-1:0] pc_seq_out;
    logic [15:0]   stall_count_out;

    typedef struct {
        bit          in_valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [CW-1:0] ctrl;
        bit          flush;
        bit          exl_v;
        logic [4:0]  exl_d;
        bit          wb_en;
        logic [4:0]  wb_dest;
        logic [31:0] wb_data;
        bit          out_ready;
    } stim_t;

    typedef struct {
        logic [31:0]   instr;
        logic [31:0]   pc;
        logic [CW-1:0] ctrl;
    } inst_t;

    typedef struct {
        logic [31:0]   a;
        logic [31:0]   b;
        logic [31:0]   s;
        logic [31:0]   pc;
        logic [4:0]    dest;
        logic [CW-1:0] ctrl;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;

    bit          m_id_v;
    bit          m_out_v;
    inst_t       m_id;
    exp_t        m_out;
    int          m_stall;
    logic [31:0] m_regs [32];

    decode_hazard_stage #(
        .DATA_W(DW), .REG_ADDR_W(AW), .CTRL_W(CW), .ZERO_REG(1)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .pc_seq_in(pc_seq_in), .ctrl_in(ctrl_in),
        .flush(flush),
        .ex_load_valid(ex_load_valid), .ex_load_dest(ex_load_dest),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .operand_a_out(operand_a_out), .operand_b_out(operand_b_out),
        .store_data_out(store_data_out), .dest_out(dest_out),
        .ctrl_out(ctrl_out), .pc_seq_out(pc_seq_out),
        .stall_count_out(stall_count_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [CW-1:0] mk_ctrl(input bit use_imm, input bit imm_uns, input bit uses_rt, input logic [1:0] dsel);
        return {21'h0A5A5, dsel, uses_rt, imm_uns, use_imm};
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s.in_valid = 1'b0; s.instr = '0; s.pc = '0; s.ctrl = '0;
        s.flush = 1'b0; s.exl_v = 1'b0; s.exl_d = '0;
        s.wb_en = 1'b0; s.wb_dest = '0; s.wb_data = '0;
        s.out_ready = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.in_valid = ($urandom_range(99) < 75);
        s.instr = $urandom;
        s.instr[25:21] = 5'($urandom_range(7));
        s.instr[20:16] = 5'($urandom_range(7));
        s.instr[15:11] = 5'($urandom_range(7));
        s.pc = $urandom;
        s.ctrl = CW'($urandom);
        s.flush = ($urandom_range(99) < 4);
        s.exl_v = ($urandom_range(99) < 30);
        s.exl_d = 5'($urandom_range(7));
        s.wb_en = ($urandom_range(99) < 50);
        s.wb_dest = 5'($urandom_range(7));
        s.wb_data = $urandom;
        s.out_ready = ($urandom_range(99) < 70);
        return s;
    endfunction

    // Register value seen by a read in the cycle carrying stimulus s.
    function automatic logic [31:0] m_read(input int addr, input stim_t s);
        if (addr == 0) return 32'h0;
        if (s.wb_en && int'(s.wb_dest) == addr) return s.wb_data;
        return m_regs[addr];
    endfunction

    function automatic exp_t m_decode(input inst_t i, input stim_t s);
        exp_t e;
        int rs; int rt; int rd; int imm16; int dsel;
        rs = int'(i.instr[25:21]);
        rt = int'(i.instr[20:16]);
        rd = int'(i.instr[15:11]);
        imm16 = int'(i.instr[15:0]);
        dsel = int'(i.ctrl[4:3]);
        e.a = m_read(rs, s);
        e.s = m_read(rt, s);
        if (i.ctrl[0]) begin
            if (i.ctrl[1] || imm16 < 32768) e.b = 32'(imm16);
            else e.b = 32'(imm16 - 65536);
        end else begin
            e.b = e.s;
        end
        case (dsel)
            0: e.dest = 5'(rt);
            1: e.dest = 5'(rd);
            2: e.dest = 5'd31;
            default: e.dest = 5'd0;
        endcase
        e.ctrl = i.ctrl;
        e.pc = i.pc;
        return e;
    endfunction

    function automatic bit m_hazard(input stim_t s);
        int rs; int rt;
        if (!m_id_v || !s.exl_v || s.exl_d == 5'd0) return 1'b0;
        rs = int'(m_id.instr[25:21]);
        rt = int'(m_id.instr[20:16]);
        return (int'(s.exl_d) == rs) || (m_id.ctrl[2] && int'(s.exl_d) == rt);
    endfunction

    // Drive one cycle of stimulus, check the handshake state, advance the model.
    task automatic applyStimulus(input stim_t s);
        bit hz; bit adv; bit exp_ready;
        @(negedge clk);
        in_valid = s.in_valid; instr_in = s.instr; pc_seq_in = s.pc; ctrl_in = s.ctrl;
        flush = s.flush; ex_load_valid = s.exl_v; ex_load_dest = s.exl_d;
        wb_en = s.wb_en; wb_dest = s.wb_dest; wb_data = s.wb_data;
        out_ready = s.out_ready;
        #1;
        hz = m_hazard(s);
        adv = !m_out_v || s.out_ready;
        exp_ready = !s.flush && (!m_id_v || (adv && !hz));
        checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
        checkOutput("out_valid", 64'(out_valid), 64'(m_out_v));
        checkOutput("stall_count", 64'(stall_count_out), 64'(m_stall));
        if (m_out_v && s.out_ready) exp_q.push_back(m_out);
        if (!s.flush && adv && hz && m_stall < 65535) m_stall++;
        if (s.flush) begin
            m_id_v = 1'b0;
            m_out_v = 1'b0;
        end else begin
            if (adv) begin
                m_out_v = m_id_v && !hz;
                if (m_out_v) m_out = m_decode(m_id, s);
            end
            if (s.in_valid && exp_ready) begin
                m_id.instr = s.instr; m_id.pc = s.pc; m_id.ctrl = s.ctrl;
                m_id_v = 1'b1;
            end else if (adv && !hz) begin
                m_id_v = 1'b0;
            end
        end
        if (s.wb_en && s.wb_dest != 5'd0) m_regs[s.wb_dest] = s.wb_data;
    endtask

    // Pulse reset for one cycle and check that everything clears at once.
    task automatic doReset();
        stim_t s;
        s = idle_stim();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0; flush = 1'b0; ex_load_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_operand_a", 64'(operand_a_out), 64'd0);
        checkOutput("rst_operand_b", 64'(operand_b_out), 64'd0);
        checkOutput("rst_store_data", 64'(store_data_out), 64'd0);
        checkOutput("rst_dest", 64'(dest_out), 64'd0);
        checkOutput("rst_ctrl", 64'(ctrl_out), 64'd0);
        checkOutput("rst_pc_seq", 64'(pc_seq_out), 64'd0);
        checkOutput("rst_stall_count", 64'(stall_count_out), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        m_id_v = 1'b0; m_out_v = 1'b0; m_stall = 0;
        foreach (m_regs[i]) m_regs[i] = '0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(s);
    endtask

    // Monitor: whenever the DUT hands an instruction to execute, compare it with the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("operand_a", 64'(operand_a_out), 64'(e.a));
                    checkOutput("operand_b", 64'(operand_b_out), 64'(e.b));
                    checkOutput("store_data", 64'(store_data_out), 64'(e.s));
                    checkOutput("dest", 64'(dest_out), 64'(e.dest));
                    checkOutput("ctrl", 64'(ctrl_out), 64'(e.ctrl));
                    checkOutput("pc_seq", 64'(pc_seq_out), 64'(e.pc));
                end
            end
        end
    end

    // Main sequence: directed scenarios first, then randomized traffic with periodic resets.
    initial begin
        stim_t s;
        doReset();

        s = idle_stim(); s.in_valid = 1'b1; s.instr = 32'h2008FFFF; s.pc = 32'h104;
        s.ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 2'b00);
        applyStimulus(s);
        applyStimulus(idle_stim());
        checkOutput("addi_not_early", 64'(out_valid), 64'd0);
        applyStimulus(idle_stim());
        checkOutput("addi_valid", 64'(out_valid), 64'd1);
        checkOutput("addi_operand_b", 64'(operand_b_out), 64'hFFFFFFFF);
        checkOutput("addi_dest", 64'(dest_out), 64'd8);

        s = idle_stim(); s.in_valid = 1'b1; s.instr = 32'h34058000; s.pc = 32'h108;
        s.ctrl = mk_ctrl(1'b1, 1'b1, 1'b0, 2'b00);
        applyStimulus(s);
        applyStimulus(idle_stim());
        applyStimulus(idle_stim());
        checkOutput("ori_operand_b", 64'(operand_b_out), 64'h00008000);
        checkOutput("ori_dest", 64'(dest_out), 64'd5);

        s = idle_stim(); s.in_valid = 1'b1; s.instr = 32'h01205020; s.pc = 32'h10C;
        s.ctrl = mk_ctrl(1'b0, 1'b0, 1'b1, 2'b01);
        applyStimulus(s);
        s = idle_stim(); s.wb_en = 1'b1; s.wb_dest = 5'd9; s.wb_data = 32'h1234;
        applyStimulus(s);
        applyStimulus(idle_stim());
        checkOutput("bypass_operand_a", 64'(operand_a_out), 64'h1234);
        checkOutput("bypass_dest", 64'(dest_out), 64'd10);

        s = idle_stim(); s.in_valid = 1'b1; s.instr = 32'h01205820; s.pc = 32'h110;
        s.ctrl = mk_ctrl(1'b0, 1'b0, 1'b1, 2'b01);
        applyStimulus(s);
        s = idle_stim(); s.in_valid = 1'b1; s.instr = 32'h2008FFFF; s.pc = 32'h114;
        s.ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 2'b00); s.exl_v = 1'b1; s.exl_d = 5'd9;
        applyStimulus(s);
        checkOutput("hazard_in_ready", 64'(in_ready), 64'd0);
        s.exl_v = 1'b0;
        applyStimulus(s);
        checkOutput("hazard_bubble", 64'(out_valid), 64'd0);
        checkOutput("hazard_stall_count", 64'(stall_count_out), 64'd1);
        applyStimulus(idle_stim());
        checkOutput("hazard_release_a", 64'(operand_a_out), 64'h1234);
        applyStimulus(idle_stim());
        applyStimulus(idle_stim());

        s = idle_stim(); s.in_valid = 1'b1; s.instr = 32'h20010011; s.pc = 32'h200;
        s.ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 2'b00);
        applyStimulus(s);
        s.instr = 32'h20020022; s.pc = 32'h204;
        applyStimulus(s);
        s.instr = 32'h20030033; s.pc = 32'h208; s.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(s);
            checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
            checkOutput("hold_pc_seq", 64'(pc_seq_out), 64'h200);
        end
        s.out_ready = 1'b1;
        applyStimulus(s);
        for (int k = 0; k < 3; k++) applyStimulus(idle_stim());

        s = idle_stim(); s.in_valid = 1'b1; s.instr = 32'h20040044; s.pc = 32'h300;
        s.ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 2'b00);
        applyStimulus(s);
        s.instr = 32'h20050055; s.pc = 32'h304;
        applyStimulus(s);
        s = idle_stim(); s.out_ready = 1'b0; s.flush = 1'b1;
        s.wb_en = 1'b1; s.wb_dest = 5'd3; s.wb_data = 32'h55;
        applyStimulus(s);
        checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
        s = idle_stim(); s.in_valid = 1'b1; s.instr = 32'h00602020; s.pc = 32'h308;
        s.ctrl = mk_ctrl(1'b0, 1'b0, 1'b1, 2'b01);
        applyStimulus(s);
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_id_empty", 64'(in_ready), 64'd1);
        applyStimulus(idle_stim());
        applyStimulus(idle_stim());
        checkOutput("flush_wb_read", 64'(operand_a_out), 64'h55);

        s = idle_stim(); s.in_valid = 1'b1; s.instr = 32'h20060066; s.pc = 32'h400;
        s.ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 2'b00);
        applyStimulus(s);
        s.instr = 32'h20070077; s.pc = 32'h404;
        applyStimulus(s);
        s.out_ready = 1'b0; s.in_valid = 1'b0;
        applyStimulus(s);
        doReset();
        for (int k = 0; k < 3; k++) applyStimulus(idle_stim());

        for (int blk = 0; blk < 3; blk++) begin
            for (int n = 0; n < 1500; n++) applyStimulus(rand_stim());
            doReset();
        end

        for (int k = 0; k < 4; k++) applyStimulus(idle_stim());
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
